// File: rtl/rv32_mc.sv
// Multi-cycle RV32I core with a single req/ack memory bus, trap detection and retire strobe.
// Optional performance counters are enabled by defining RV32_MC_PERF_EN.
module rv32_mc #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ack_i,
  output logic             instr_done_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [WIDTH-1:0] cycle_cnt_o,
  output logic [WIDTH-1:0] instret_o
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBeq, StJal, StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [WIDTH-1:0] TimeoutLim = WIDTH'(BUS_TIMEOUT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, old_pc_q, old_pc_d, res_q, res_d;
  logic [31:0]      ir_q, ir_d;
  logic             req_q, req_d, we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [WIDTH-1:0] rf_q [32];

  logic [6:0]       opcode;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1_val, rs2_val, imm, alu_b, alu_res, ls_addr, target;
  logic             stall, ack_ok, timeout, done, preload, rf_we;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  always_comb begin
    case (opcode)
      OpStore:  imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OpBranch: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OpJal:    imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:  imm = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  assign alu_b = (opcode == OpReg) ? rs2_val : imm;

  always_comb begin
    case (funct3)
      3'b000:  alu_res = (opcode == OpReg && ir_q[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b010:  alu_res = {{(WIDTH-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
      3'b110:  alu_res = rs1_val | alu_b;
      3'b111:  alu_res = rs1_val & alu_b;
      default: alu_res = rs1_val + alu_b;
    endcase
  end

  assign ls_addr = rs1_val + imm;
  assign target  = old_pc_q + imm;
  assign stall   = req_q && !mem_ack_i;
  assign ack_ok  = req_q && mem_ack_i;
  assign timeout = (TimeoutLim != '0) && stall && (wait_q + WIDTH'(1) == TimeoutLim);
  assign wait_d  = stall ? wait_q + WIDTH'(1) : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    ir_d     = ir_q;
    res_d    = res_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cause_d  = cause_q;
    done     = 1'b0;
    preload  = 1'b0;
    rf_we    = 1'b0;

    case (state_q)
      StFetch: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (ack_ok) begin
          ir_d     = mem_rdata_i;
          old_pc_d = pc_q;
          pc_d     = pc_q + WIDTH'(4);
          req_d    = 1'b0;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default: begin
            cause_d = 2'b01;
            state_d = StTrap;
          end
        endcase
      end
      StMemAdr: begin
        if (ls_addr[1:0] != 2'b00) begin
          cause_d = 2'b11;
          state_d = StTrap;
        end else begin
          req_d  = 1'b1;
          addr_d = ls_addr;
          if (opcode == OpStore) begin
            we_d    = 1'b1;
            wdata_d = rs2_val;
            state_d = StMemWrite;
          end else begin
            we_d    = 1'b0;
            state_d = StMemRead;
          end
        end
      end
      StMemRead: begin
        if (ack_ok) begin
          res_d   = mem_rdata_i;
          req_d   = 1'b0;
          state_d = StMemWb;
        end
      end
      StMemWrite: begin
        // Fetch is not preloaded here so req drops for a cycle between accesses.
        if (ack_ok) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          done    = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR, StExecI: begin
        res_d   = alu_res;
        state_d = StAluWb;
      end
      StMemWb, StAluWb: begin
        rf_we   = 1'b1;
        preload = 1'b1;
      end
      StBeq: begin
        if (rs1_val == rs2_val && target[1:0] != 2'b00) begin
          cause_d = 2'b11;
          state_d = StTrap;
        end else begin
          if (rs1_val == rs2_val) pc_d = target;
          preload = 1'b1;
        end
      end
      StJal: begin
        if (target[1:0] != 2'b00) begin
          cause_d = 2'b11;
          state_d = StTrap;
        end else begin
          pc_d    = target;
          res_d   = old_pc_q + WIDTH'(4);
          state_d = StAluWb;
        end
      end
      default: ;
    endcase

    // Terminal states issue the next fetch directly so it costs no extra cycle.
    if (preload) begin
      done    = 1'b1;
      state_d = StFetch;
      req_d   = 1'b1;
      we_d    = 1'b0;
      addr_d  = pc_d;
    end

    if (timeout) begin
      cause_d = 2'b10;
      state_d = StTrap;
      req_d   = 1'b0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      old_pc_q <= '0;
      ir_q     <= '0;
      res_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cause_q  <= 2'b00;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      ir_q     <= ir_d;
      res_q    <= res_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cause_q  <= cause_d;
      wait_q   <= wait_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rf_we && rd != 5'd0) rf_q[rd] <= res_q;
  end

  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign instr_done_o = done;
  assign trap_o       = (state_q == StTrap);
  assign trap_cause_o = cause_q;

`ifdef RV32_MC_PERF_EN
  logic [WIDTH-1:0] cycle_q, instret_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state_q != StTrap) begin
      cycle_q <= cycle_q + WIDTH'(1);
      if (done) instret_q <= instret_q + WIDTH'(1);
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;
`else
  assign cycle_cnt_o = '0;
  assign instret_o   = '0;
`endif

endmodule

// File: tb/tb_rv32_mc.sv
// Directed bench for rv32_mc: a small bus responder with programmable wait states plus
// hand-computed expectations for retire timing, bus traffic, stored results and traps.
module tb_rv32_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req, we, ack, done, trap;
  logic [31:0] addr, wdata, rdata, ccnt, iret;
  logic [1:0]  cause;

  rv32_mc #(.WIDTH(32), .RESET_PC(32'h0000_0100), .BUS_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr),
    .mem_wdata_o(wdata), .mem_rdata_i(rdata), .mem_ack_i(ack), .instr_done_o(done),
    .trap_o(trap), .trap_cause_o(cause), .cycle_cnt_o(ccnt), .instret_o(iret)
  );

  always #5 clk = ~clk;

`ifdef RV32_MC_PERF_EN
  localparam logic [31:0] ExpCycTrap = 32'd7;
  localparam logic [31:0] ExpRetTrap = 32'd1;
`else
  localparam logic [31:0] ExpCycTrap = 32'd0;
  localparam logic [31:0] ExpRetTrap = 32'd0;
`endif

  logic [31:0] mem [256];
  int          dwait = 0;
  bit          ack_en = 1'b1;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;
  int          retire_cyc[$];
  int          req_cyc[$];
  logic [31:0] req_addr[$];
  int          st_hold = 0;
  int          trap_cyc = -1;
  logic        req_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] next_after(input logic [31:0] a);
    for (int i = 0; i + 1 < req_addr.size(); i++)
      if (req_addr[i] == a) return req_addr[i + 1];
    return 32'hDEAD_DEAD;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst_n) cyc++;
  end

  // Bus responder: data accesses below 0x100 see dwait wait states, fetches none.
  initial begin
    int wcnt;
    ack = 1'b0;
    rdata = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!req || ack) begin
        ack = 1'b0;
        wcnt = 0;
      end else if (ack_en && wcnt >= ((addr < 32'h100) ? dwait : 0)) begin
        ack = 1'b1;
        if (we) mem[addr[9:2]] = wdata;
        rdata = mem[addr[9:2]];
      end else begin
        wcnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (done) retire_cyc.push_back(cyc);
      if (req && !req_prev) begin
        req_addr.push_back(addr);
        req_cyc.push_back(cyc);
      end
      if (req && we && addr == 32'd8 && wdata == 32'd10) st_hold++;
      if (trap && trap_cyc < 0) trap_cyc = cyc;
      req_prev = req;
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    retire_cyc.delete();
    req_cyc.delete();
    req_addr.delete();
    st_hold = 0;
    trap_cyc = -1;
  endtask

  task automatic go(input int w, input bit en);
    dwait = w;
    ack_en = en;
    @(negedge clk);
    #2;
    cyc = 0;
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  initial begin
    logic [31:0] c0;
    #1;
    hold_reset();
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_cause", {30'b0, cause}, 32'd0);
    check("rst_cyc", ccnt, 32'd0);
    check("rst_iret", iret, 32'd0);

    // addi/add, then sw/lw with three wait states on data accesses
    ld(32'h100, 32'h00500093); ld(32'h104, 32'h00108133); ld(32'h108, 32'h00202423);
    ld(32'h10C, 32'h00802183); ld(32'h110, 32'h00302623); ld(32'h114, 32'h00000063);
    go(3, 1'b1);
    run(45);
    check("addi_retire", 32'(retire_cyc[0]), 32'd4);
    check("add_retire", 32'(retire_cyc[1]), 32'd8);
    check("sw_retire", 32'(retire_cyc[2]), 32'd15);
    check("lw_retire", 32'(retire_cyc[3]), 32'd24);
    check("sw_hold", 32'(st_hold), 32'd4);
    check("mem8_x2", mem[2], 32'd10);
    check("lw_fetch_addr", req_addr[4], 32'h10C);
    check("lw_len", 32'(retire_cyc[3] - req_cyc[4] + 1), 32'd8);
    check("mem12_x3", mem[3], 32'd10);

    // jal to 0x10, taken beq -4, store of the link value
    hold_reset();
    ld(32'h100, 32'hF11FF2EF); ld(32'h010, 32'hFE000EE3); ld(32'h00C, 32'h02502023);
    go(0, 1'b1);
    run(20);
    check("jal_retire", 32'(retire_cyc[0]), 32'd4);
    check("jal_target", req_addr[1], 32'h10);
    check("beq_taken_next", next_after(32'h10), 32'h0C);
    check("beq_len", 32'(retire_cyc[1] - retire_cyc[0]), 32'd3);
    check("jal_link", mem[8], 32'h104);

    // ALU ops, x0 write discard, not-taken beq
    hold_reset();
    ld(32'h100, 32'hFFD00093); ld(32'h104, 32'h00700013); ld(32'h108, 32'h0000A133);
    ld(32'h10C, 32'h401001B3); ld(32'h110, 32'h0F00F213); ld(32'h114, 32'h002262B3);
    ld(32'h118, 32'h04202023); ld(32'h11C, 32'h04302223); ld(32'h120, 32'h04002423);
    ld(32'h124, 32'h04502623); ld(32'h128, 32'h00010463); ld(32'h12C, 32'h00000063);
    go(0, 1'b1);
    run(70);
    check("slt", mem[16], 32'd1);
    check("sub", mem[17], 32'd3);
    check("x0_discard", mem[18], 32'd0);
    check("andi_or", mem[19], 32'hF1);
    check("beq_not_taken", next_after(32'h128), 32'h12C);

    // illegal opcode after one retired instruction
    hold_reset();
    ld(32'h100, 32'h00500093); ld(32'h104, 32'h0000007F);
    go(0, 1'b1);
    run(12);
    c0 = ccnt;
    check("ill_trap", {31'b0, trap}, 32'd1);
    check("ill_cause", {30'b0, cause}, 32'd1);
    check("ill_cyc", c0, ExpCycTrap);
    check("ill_iret", iret, ExpRetTrap);
    run(6);
    check("ill_no_req", 32'(req_addr.size()), 32'd2);
    check("ill_cyc_frozen", ccnt, ExpCycTrap);

    // bus timeout on a fetch that is never acknowledged
    hold_reset();
    go(0, 1'b0);
    run(12);
    check("to_delay", 32'(trap_cyc - req_cyc[0]), 32'd4);
    check("to_cause", {30'b0, cause}, 32'd2);
    check("to_req_low", {31'b0, req}, 32'd0);

    // misaligned load address traps before any data request
    hold_reset();
    ld(32'h100, 32'h00202083);
    go(0, 1'b1);
    run(12);
    check("mis_trap", {31'b0, trap}, 32'd1);
    check("mis_cause", {30'b0, cause}, 32'd3);
    check("mis_no_req", 32'(req_addr.size()), 32'd1);

    // reset during a stalled fetch
    hold_reset();
    go(0, 1'b0);
    run(3);
    check("stall_req_high", {31'b0, req}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_drops_req", {31'b0, req}, 32'd0);
    hold_reset();
    ld(32'h100, 32'h00500093);
    go(0, 1'b1);
    run(6);
    check("rerun_addr", req_addr[0], 32'h100);
    check("rerun_cyc", 32'(req_cyc[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
